// File: rtl/display_pkg.sv
// Shared definitions for the scroll display: blanking constants, digit
// geometry, the controller state encoding and the digit-select helper.
package display_pkg;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;  // all segments off (active low)
    localparam logic [6:0] TRANS_OFF  = 7'h7F;  // no digit selected (active low)
    localparam int         NUM_DIGITS = 7;
    localparam int         CHAR_MAX   = 62;     // highest index with a glyph

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SCROLL,
        PAUSE
    } state_t;

    // Active-low select for digit d; digit 0 is the leftmost (bit 6).
    function automatic logic [6:0] digit_sel(input logic [2:0] d);
        return ~(7'b1000000 >> d);
    endfunction

endpackage

// File: rtl/char_seg_rom.sv
// Clocked character-index to 7-segment lookup (one cycle of latency).
// Glyphs: 0-9 digits, 10-35 upper-case letters, 36-61 lower-case letters,
// 62 a dash. Anything above CHAR_MAX decodes to an all-off pattern.
// Segment order is {g,f,e,d,c,b,a}; the output is active low.
module char_seg_rom
    import display_pkg::*;
#(
    parameter int CHAR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CHAR_W-1:0] idx,
    output logic [6:0]        seg
);

    logic [6:0] lit;   // active-high glyph, inverted on registration
    int         code;

    // Glyph table in active-high form; unknown indices light nothing.
    always_comb begin
        // NOTE: default first so every path assigns lit and no latch is inferred.
        lit  = 7'h00;
        code = int'(idx);
        case (code)
            0:  lit = 7'h3F;  1:  lit = 7'h06;  2:  lit = 7'h5B;  3:  lit = 7'h4F;
            4:  lit = 7'h66;  5:  lit = 7'h6D;  6:  lit = 7'h7D;  7:  lit = 7'h07;
            8:  lit = 7'h7F;  9:  lit = 7'h6F;
            10: lit = 7'h77;  11: lit = 7'h7C;  12: lit = 7'h39;  13: lit = 7'h5E;
            14: lit = 7'h79;  15: lit = 7'h71;  16: lit = 7'h3D;  17: lit = 7'h76;
            18: lit = 7'h06;  19: lit = 7'h1E;  20: lit = 7'h75;  21: lit = 7'h38;
            22: lit = 7'h37;  23: lit = 7'h54;  24: lit = 7'h3F;  25: lit = 7'h73;
            26: lit = 7'h67;  27: lit = 7'h50;  28: lit = 7'h6D;  29: lit = 7'h78;
            30: lit = 7'h3E;  31: lit = 7'h1C;  32: lit = 7'h2A;  33: lit = 7'h76;
            34: lit = 7'h6E;  35: lit = 7'h5B;
            36: lit = 7'h5F;  37: lit = 7'h7C;  38: lit = 7'h58;  39: lit = 7'h5E;
            40: lit = 7'h7B;  41: lit = 7'h71;  42: lit = 7'h6F;  43: lit = 7'h74;
            44: lit = 7'h04;  45: lit = 7'h0E;  46: lit = 7'h75;  47: lit = 7'h30;
            48: lit = 7'h55;  49: lit = 7'h54;  50: lit = 7'h5C;  51: lit = 7'h73;
            52: lit = 7'h67;  53: lit = 7'h50;  54: lit = 7'h6D;  55: lit = 7'h78;
            56: lit = 7'h1C;  57: lit = 7'h1C;  58: lit = 7'h2A;  59: lit = 7'h76;
            60: lit = 7'h6E;  61: lit = 7'h5B;
            62: lit = 7'h40;
            default: lit = 7'h00;
        endcase
    end

    // Register the active-low pattern; reset shows a dark digit.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (rst) seg <= SEG_BLANK;
        else     seg <= ~lit;
    end

endmodule

// File: rtl/scroll_display.sv
// Run-mode scrolling message display. When mode falls to 0 the seven
// character indices are captured and scrolled leftward across a 7-digit
// multiplexed, active-low 7-segment display.
// Optional feature macro: SCROLL_GAP_EN -- appends seven blank positions so
// the message clears fully before repeating (message length 14 instead of 7).
module scroll_display
    import display_pkg::*;
#(
    parameter int SCAN_DIV = 25000,
    parameter int STEP_DIV = 12500000,
    parameter int CHAR_W   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              pause,
    input  logic [CHAR_W-1:0] char0,
    input  logic [CHAR_W-1:0] char1,
    input  logic [CHAR_W-1:0] char2,
    input  logic [CHAR_W-1:0] char3,
    input  logic [CHAR_W-1:0] char4,
    input  logic [CHAR_W-1:0] char5,
    input  logic [CHAR_W-1:0] char6,
    output logic [6:0]        trans,
    output logic [6:0]        led7seg,
    output logic [3:0]        scroll_pos
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);

`ifdef SCROLL_GAP_EN
    localparam int MSG_LEN = 14;
`else
    localparam int MSG_LEN = 7;
`endif
    localparam logic [3:0] POS_LAST = 4'(MSG_LEN - 1);

    state_t             state;
    state_t             state_next;
    logic               load;
    logic               run;       // scan and display active this cycle
    logic               step_en;   // scroll timer advances this cycle

    logic [SCAN_W-1:0]  scan_cnt;
    logic [2:0]         digit;
    logic [STEP_W-1:0]  step_cnt;
    logic [CHAR_W-1:0]  msg_buf [NUM_DIGITS];

    logic [4:0]         pos_sum;
    logic [2:0]         slot;
    logic               gap_blank;
    logic [CHAR_W-1:0]  rom_idx;
    logic [6:0]         trans_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic; mode=1 overrides everything, including a pause pulse.
    always_comb begin
        state_next = state;
        if (mode) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = LOAD;
                LOAD:    state_next = SCROLL;
                SCROLL:  if (pause) state_next = PAUSE;
                PAUSE:   if (pause) state_next = SCROLL;
                default: state_next = IDLE;
            endcase
        end
    end

    // State-decoded controls; a pause pulse in SCROLL blocks that cycle's step.
    always_comb begin
        load    = (state == LOAD);
        run     = ((state == SCROLL) || (state == PAUSE)) && !mode;
        step_en = (state == SCROLL) && !mode && !pause;
    end

    // Message snapshot, taken only in LOAD so later char changes are ignored.
    always_ff @(posedge clk) begin
        // NOTE: this small buffer is reset because its reset contents are defined behaviour.
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) msg_buf[i] <= '0;
        end else if (load) begin
            msg_buf[0] <= char0;
            msg_buf[1] <= char1;
            msg_buf[2] <= char2;
            msg_buf[3] <= char3;
            msg_buf[4] <= char4;
            msg_buf[5] <= char5;
            msg_buf[6] <= char6;
        end
    end

    // Digit scan: refresh timer stepping the active digit 0..6.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            scan_cnt <= '0;
            digit    <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            digit    <= (digit == 3'd6) ? 3'd0 : digit + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Scroll step: timer advancing the message offset; frozen while paused.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            step_cnt   <= '0;
            scroll_pos <= '0;
        end else if (step_en) begin
            if (step_cnt == STEP_LAST) begin
                step_cnt   <= '0;
                scroll_pos <= (scroll_pos == POS_LAST) ? 4'd0 : scroll_pos + 4'd1;
            end else begin
                step_cnt <= step_cnt + 1'b1;
            end
        end
    end

    // Message position shown on the active digit, modulo the message length.
    always_comb begin
        pos_sum = {1'b0, scroll_pos} + {2'b00, digit};
`ifdef SCROLL_GAP_EN
        begin : gap_wrap
            logic [4:0] wrapped;
            wrapped   = (pos_sum >= 5'd14) ? pos_sum - 5'd14 : pos_sum;
            gap_blank = (wrapped >= 5'd7);
            slot      = gap_blank ? 3'd0 : 3'(wrapped);
        end
`else
        gap_blank = 1'b0;
        slot      = (pos_sum >= 5'd7) ? 3'(pos_sum - 5'd7) : pos_sum[2:0];
`endif
        rom_idx = (run && !gap_blank) ? msg_buf[slot] : '1;
    end

    // Digit select delayed to line up with the registered segment lookup.
    always_ff @(posedge clk) begin
        if (rst) trans_q <= TRANS_OFF;
        else     trans_q <= run ? digit_sel(digit) : TRANS_OFF;
    end

    char_seg_rom #(.CHAR_W(CHAR_W)) u_rom (
        .clk (clk),
        .rst (rst),
        .idx (rom_idx),
        .seg (led7seg)
    );

    assign trans = trans_q;

endmodule

// File: tb/tb_scroll_display.sv
// Self-checking bench for scroll_display with SCAN_DIV=2, STEP_DIV=20.
// A table of hand-computed {cycle, trans, led7seg, scroll_pos} records covers
// the first scroll after run mode starts; short directed sequences cover
// pause, snapshot isolation, blank glyphs, mode/pause collision and reset.
module tb_scroll_display;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic       pause;
    logic [6:0] ch [7];
    logic [6:0] trans;
    logic [6:0] led7seg;
    logic [3:0] scroll_pos;

    int n_cmp = 0;
    int n_bad = 0;

    scroll_display #(.SCAN_DIV(2), .STEP_DIV(20), .CHAR_W(7)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .pause      (pause),
        .char0      (ch[0]),
        .char1      (ch[1]),
        .char2      (ch[2]),
        .char3      (ch[3]),
        .char4      (ch[4]),
        .char5      (ch[5]),
        .char6      (ch[6]),
        .trans      (trans),
        .led7seg    (led7seg),
        .scroll_pos (scroll_pos)
    );

    always #5 clk = ~clk;

    // Active-low glyphs for the indices used here.
    localparam logic [6:0] R0  = 7'h40;
    localparam logic [6:0] R1  = 7'h79;
    localparam logic [6:0] R2  = 7'h24;
    localparam logic [6:0] R3  = 7'h30;
    localparam logic [6:0] R4  = 7'h19;
    localparam logic [6:0] R5  = 7'h12;
    localparam logic [6:0] R6  = 7'h02;
    localparam logic [6:0] R40 = 7'h04;
    localparam logic [6:0] R62 = 7'h3F;
    localparam logic [6:0] BLK = 7'h7F;

    typedef struct {
        int         n;
        logic [6:0] trans;
        logic [6:0] seg;
        logic [3:0] pos;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_chars(input int c0, input int c1, input int c2, input int c3,
                             input int c4, input int c5, input int c6);
        ch[0] = 7'(c0); ch[1] = 7'(c1); ch[2] = 7'(c2); ch[3] = 7'(c3);
        ch[4] = 7'(c4); ch[5] = 7'(c5); ch[6] = 7'(c6);
    endtask

    initial begin
        int vi;
        int bad;
        int saw_a;
        int saw_b;
        logic [6:0] seen;
        logic [3:0] prev_pos;

        rst   = 1'b1;
        mode  = 1'b1;
        pause = 1'b0;
        set_chars(0, 1, 2, 3, 4, 5, 6);
        tick();
        tick();
        rst = 1'b0;

        // Setting mode: blank and idle for 100 cycles.
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (trans !== BLK || led7seg !== BLK || scroll_pos !== 4'd0) bad++;
            if (i == 0) begin
                check("reset_trans", {1'b0, trans}, 8'h7F);
                check("reset_seg", {1'b0, led7seg}, 8'h7F);
                check("reset_pos", {4'h0, scroll_pos}, 8'h00);
            end
        end
        check("idle_100_bad_cycles", 8'(bad), 8'd0);

`ifndef SCROLL_GAP_EN
        // Table: cycle n counts edges after mode is first sampled 0.
        vecs.push_back('{0,   7'h7F, BLK, 4'd0});
        vecs.push_back('{1,   7'h7F, BLK, 4'd0});
        vecs.push_back('{2,   7'h3F, R0,  4'd0});
        vecs.push_back('{3,   7'h3F, R0,  4'd0});
        vecs.push_back('{4,   7'h5F, R1,  4'd0});
        vecs.push_back('{14,  7'h7E, R6,  4'd0});
        vecs.push_back('{16,  7'h3F, R0,  4'd0});
        vecs.push_back('{20,  7'h6F, R2,  4'd0});
        vecs.push_back('{21,  7'h6F, R2,  4'd1});
        vecs.push_back('{22,  7'h77, R4,  4'd1});
        vecs.push_back('{28,  7'h7E, R0,  4'd1});
        vecs.push_back('{30,  7'h3F, R1,  4'd1});
        vecs.push_back('{42,  7'h7E, R1,  4'd2});
        vecs.push_back('{140, 7'h7E, R5,  4'd6});
        vecs.push_back('{141, 7'h7E, R5,  4'd0});
        vecs.push_back('{142, 7'h3F, R0,  4'd0});

        mode = 1'b0;
        vi   = 0;
        for (int n = 0; n <= 142; n++) begin
            tick();
            if (vi < vecs.size() && vecs[vi].n == n) begin
                check($sformatf("vec%0d_trans", n), {1'b0, trans}, {1'b0, vecs[vi].trans});
                check($sformatf("vec%0d_seg", n), {1'b0, led7seg}, {1'b0, vecs[vi].seg});
                check($sformatf("vec%0d_pos", n), {4'h0, scroll_pos}, {4'h0, vecs[vi].pos});
                vi++;
            end
        end
        check("vec_table_consumed", 8'(vi), 8'(vecs.size()));

        // Pause pulse lands when step_cnt is 10 (after edge 151).
        repeat (9) tick();
        pause = 1'b1;
        tick();
        pause = 1'b0;
        bad  = 0;
        seen = 7'h00;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (scroll_pos !== 4'd0) bad++;
            seen = seen | ~trans;
        end
        check("pause_pos_frozen", 8'(bad), 8'd0);
        check("pause_scan_runs", {1'b0, seen}, 8'h7F);
        pause = 1'b1;
        tick();
        pause = 1'b0;
        repeat (9) tick();
        check("resume_pos_before", {4'h0, scroll_pos}, 8'h00);
        tick();
        check("resume_pos_after10", {4'h0, scroll_pos}, 8'h01);

        // mode=1 together with pause: straight to idle, blank.
        mode  = 1'b1;
        pause = 1'b1;
        tick();
        pause = 1'b0;
        tick();
        check("mode_pause_trans", {1'b0, trans}, 8'h7F);
        check("mode_pause_seg", {1'b0, led7seg}, 8'h7F);
        check("mode_pause_pos", {4'h0, scroll_pos}, 8'h00);

        // char3 changed mid-scroll is not shown until the next load.
        mode = 1'b0;
        repeat (30) tick();
        ch[3] = 7'd40;
        saw_a = 0;
        saw_b = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (led7seg === R40) saw_a++;
            if (led7seg === R3) saw_b++;
        end
        check("snap_new_hidden", 8'(saw_a), 8'd0);
        check("snap_old_shown", 8'(saw_b > 0), 8'd1);
        mode = 1'b1;
        repeat (3) tick();
        mode  = 1'b0;
        saw_a = 0;
        saw_b = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (led7seg === R40) saw_a++;
            if (led7seg === R3) saw_b++;
        end
        check("reload_new_shown", 8'(saw_a > 0), 8'd1);
        check("reload_old_gone", 8'(saw_b), 8'd0);

        // Index 62 has a glyph, 99 decodes blank on a selected digit.
        mode = 1'b1;
        set_chars(62, 99, 1, 2, 3, 4, 5);
        repeat (3) tick();
        mode  = 1'b0;
        saw_a = 0;
        saw_b = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (led7seg === R62) saw_a++;
            if (trans !== BLK && led7seg === BLK) saw_b++;
        end
        check("idx62_glyph", 8'(saw_a > 0), 8'd1);
        check("idx99_blank", 8'(saw_b > 0), 8'd1);
`else
        // Gap build: 14 positions, positions 7..13 and index 99 blank.
        set_chars(62, 99, 1, 2, 3, 4, 5);
        mode     = 1'b0;
        saw_a    = 0;
        saw_b    = 0;
        bad      = 0;
        prev_pos = 4'd0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (prev_pos == 4'd13 && scroll_pos == 4'd0) saw_a++;
            if (scroll_pos > 4'd13) bad++;
            if (led7seg === R62) saw_b++;
            prev_pos = scroll_pos;
        end
        check("gap_wrap_13_to_0", 8'(saw_a > 0), 8'd1);
        check("gap_pos_range", 8'(bad), 8'd0);
        check("gap_idx62_glyph", 8'(saw_b > 0), 8'd1);
        // Wait for position 7, then every digit must stay dark while there.
        vi = 0;
        while (scroll_pos != 4'd7 && vi < 400) begin
            tick();
            vi++;
        end
        check("gap_reach_pos7", 8'(scroll_pos), 8'd7);
        repeat (2) tick();
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (led7seg !== BLK) bad++;
        end
        check("gap_pos7_all_blank", 8'(bad), 8'd0);
`endif

        // Synchronous reset mid-scroll: reset values on the next cycle.
        mode = 1'b0;
        repeat (50) tick();
        rst = 1'b1;
        tick();
        check("midrst_trans", {1'b0, trans}, 8'h7F);
        check("midrst_seg", {1'b0, led7seg}, 8'h7F);
        check("midrst_pos", {4'h0, scroll_pos}, 8'h00);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
